ttc_cmd_scheduler: RTL and testbench

- Merges external TTC commands (bx0, resync, l1a, calpulse) from the GBT decoder with one locally requested command scheduled at a target BX.
- Local requests come from slow control.
- A calpulse may optionally be followed by an L1A at a programmable delay.
- Sits between the TTC decoder and the bx/orbit counter block; its BX input is that block's bxn_counter.

---
 rtl/ttc_cmd_scheduler_if.sv | 42 ++++
 rtl/ttc_cmd_scheduler.sv | 147 ++++++++++++++
 tb/tb_ttc_cmd_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ttc_cmd_scheduler_if.sv
// Signal bundle between the TTC command scheduler and its surroundings:
// external TTC strobes, the slow-control request channel and the merged outputs.
interface ttc_cmd_scheduler_if #(
  parameter int unsigned MXBXN = 12,
  parameter int unsigned MXDLY = 8,
  parameter int unsigned MXCOL = 16
);
  logic [MXBXN-1:0] bxn_counter;
  logic             ext_bx0;
  logic             ext_resync;
  logic             ext_l1a;
  logic             ext_calpulse;
  logic             ext_mask;
  logic             sw_req;
  logic [1:0]       sw_cmd;
  logic [MXBXN-1:0] sw_bx;
  logic             cal_l1a_en;
  logic [MXDLY-1:0] cal_l1a_delay;
  logic             ttc_bx0;
  logic             ttc_resync;
  logic             ttc_l1a;
  logic             ttc_calpulse;
  logic             sw_busy;
  logic             sw_done;
  logic             sw_abort;
  logic             sw_err;
  logic [MXCOL-1:0] collision_cnt;

  modport master (
    output bxn_counter, ext_bx0, ext_resync, ext_l1a, ext_calpulse, ext_mask,
    output sw_req, sw_cmd, sw_bx, cal_l1a_en, cal_l1a_delay,
    input  ttc_bx0, ttc_resync, ttc_l1a, ttc_calpulse,
    input  sw_busy, sw_done, sw_abort, sw_err, collision_cnt
  );

  modport slave (
    input  bxn_counter, ext_bx0, ext_resync, ext_l1a, ext_calpulse, ext_mask,
    input  sw_req, sw_cmd, sw_bx, cal_l1a_en, cal_l1a_delay,
    output ttc_bx0, ttc_resync, ttc_l1a, ttc_calpulse,
    output sw_busy, sw_done, sw_abort, sw_err, collision_cnt
  );
endinterface

// File: rtl/ttc_cmd_scheduler.sv
// Merges external TTC commands with one locally scheduled command fired at a target BX,
// optionally followed by a delayed L1A after a local calpulse.
module ttc_cmd_scheduler #(
  parameter int unsigned MXBXN     = 12,
  parameter int unsigned LHC_CYCLE = 3564,
  parameter int unsigned MXDLY     = 8,
  parameter int unsigned MXCOL     = 16,
  parameter int unsigned TIMEOUT   = 7128
) (
  input logic                clock,
  input logic                reset,
  ttc_cmd_scheduler_if.slave bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StArmed, StCalWait, StDone, StAbort} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [MXBXN-1:0] bx_q, bx_d;
  logic [MXDLY-1:0] dly_q, dly_d;
  logic [MXDLY-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             pend_q, pend_d;
  logic [MXCOL-1:0] col_q, col_d;
  logic             err_q, err_d;
  // Bit order matches sw_cmd encoding: 0 resync, 1 bx0, 2 calpulse, 3 l1a
  logic [3:0]       ttc_q, ttc_d;

  logic [3:0] ext_vec;
  logic [3:0] loc;
  logic       ext_any;
  logic       fire;
  logic       defer;

  assign ext_vec = {bus.ext_l1a, bus.ext_calpulse, bus.ext_bx0, bus.ext_resync}
                   & {4{~bus.ext_mask}};
  assign ext_any = |ext_vec;
  assign fire    = (bus.bxn_counter == bx_q) || pend_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    bx_d    = bx_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    loc     = '0;
    defer   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.sw_req) begin
          cmd_d   = bus.sw_cmd;
          bx_d    = (32'(bus.sw_bx) >= LHC_CYCLE) ? MXBXN'(LHC_CYCLE - 1) : bus.sw_bx;
          dly_d   = (bus.cal_l1a_delay == '0) ? MXDLY'(1) : bus.cal_l1a_delay;
          tmo_d   = '0;
          pend_d  = 1'b0;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (ext_vec[0]) begin
          pend_d  = 1'b0;
          state_d = StAbort;
        end else if (fire && !ext_any) begin
          loc[cmd_q] = 1'b1;
          pend_d     = 1'b0;
          if (cmd_q == 2'd2 && bus.cal_l1a_en) begin
            // Load delay-1 so the L1A output lands exactly dly cycles after the calpulse output
            cnt_d   = dly_q - MXDLY'(1);
            state_d = StCalWait;
          end else begin
            state_d = StDone;
          end
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          pend_d  = 1'b0;
          state_d = StAbort;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
          if (fire) begin
            pend_d = 1'b1;
            defer  = 1'b1;
          end
        end
      end
      StCalWait: begin
        if (ext_vec[0]) begin
          state_d = StAbort;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - MXDLY'(1);
        end else if (!ext_any) begin
          loc[3]  = 1'b1;
          state_d = StDone;
        end else begin
          defer = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    col_d = (defer && (col_q != '1)) ? col_q + MXCOL'(1) : col_q;
    err_d = bus.sw_req && (state_q != StIdle);
    ttc_d = ext_vec | loc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      bx_q    <= '0;
      dly_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pend_q  <= 1'b0;
      col_q   <= '0;
      err_q   <= 1'b0;
      ttc_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      bx_q    <= bx_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      col_q   <= col_d;
      err_q   <= err_d;
      ttc_q   <= ttc_d;
    end
  end

  assign bus.ttc_resync    = ttc_q[0];
  assign bus.ttc_bx0       = ttc_q[1];
  assign bus.ttc_calpulse  = ttc_q[2];
  assign bus.ttc_l1a       = ttc_q[3];
  assign bus.sw_busy       = (state_q != StIdle);
  assign bus.sw_done       = (state_q == StDone);
  assign bus.sw_abort      = (state_q == StAbort);
  assign bus.sw_err        = err_q;
  assign bus.collision_cnt = col_q;

endmodule

// File: tb/tb_ttc_cmd_scheduler.sv
// Scoreboard bench for ttc_cmd_scheduler: stimulus queues expected output events
// (cycle + output vector); a negedge monitor pops and compares every nonzero output.
module tb_ttc_cmd_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic bx_run = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ttc_cmd_scheduler_if #(.MXBXN(12), .MXDLY(8), .MXCOL(16)) bus ();

  ttc_cmd_scheduler #(
    .MXBXN(12), .LHC_CYCLE(3564), .MXDLY(8), .MXCOL(16), .TIMEOUT(7128)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Output vector: {bx0, resync, l1a, calpulse, done, abort, err}
  localparam logic [6:0] VBx0  = 7'b1000000;
  localparam logic [6:0] VRes  = 7'b0100000;
  localparam logic [6:0] VL1a  = 7'b0010000;
  localparam logic [6:0] VCal  = 7'b0001000;
  localparam logic [6:0] VDone = 7'b0000100;
  localparam logic [6:0] VAbt  = 7'b0000010;
  localparam logic [6:0] VErr  = 7'b0000001;

  logic [6:0] outvec;
  assign outvec = {bus.ttc_bx0, bus.ttc_resync, bus.ttc_l1a, bus.ttc_calpulse,
                   bus.sw_done, bus.sw_abort, bus.sw_err};

  typedef struct {
    int         at;
    logic [6:0] vec;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always @(negedge clock) begin
    if (!reset && outvec != 7'd0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cycle %0d got %b, required no event", cyc, outvec);
      end else begin
        e = q.pop_front();
        if (e.at != cyc || e.vec != outvec) begin
          errors++;
          $display("FAIL event: got cycle %0d vec %b, required cycle %0d vec %b",
                   cyc, outvec, e.at, e.vec);
        end
      end
    end
  end

  task automatic push(input int at, input logic [6:0] vec);
    exp_t x;
    x.at  = at;
    x.vec = vec;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (bx_run) bus.bxn_counter = (bus.bxn_counter == 12'd3563) ? 12'd0 : bus.bxn_counter + 12'd1;
  endtask

  // Issues a request in the current cycle n (returned) and advances to cycle n+1
  task automatic launch(input logic [1:0] cmd, input logic [11:0] bx, input logic [7:0] dly,
                        input logic [11:0] bx_start, output int n);
    n                 = cyc;
    bus.bxn_counter   = bx_start;
    bus.sw_cmd        = cmd;
    bus.sw_bx         = bx;
    bus.cal_l1a_delay = dly;
    bus.sw_req        = 1'b1;
    step();
    bus.sw_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bus.bxn_counter   = '0;
    bus.ext_bx0       = 1'b0;
    bus.ext_resync    = 1'b0;
    bus.ext_l1a       = 1'b0;
    bus.ext_calpulse  = 1'b0;
    bus.ext_mask      = 1'b0;
    bus.sw_req        = 1'b0;
    bus.sw_cmd        = '0;
    bus.sw_bx         = '0;
    bus.cal_l1a_en    = 1'b0;
    bus.cal_l1a_delay = '0;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_outputs", int'(outvec), 0);
    chk("reset_busy", int'(bus.sw_busy), 0);
    chk("reset_collision", int'(bus.collision_cnt), 0);

    // Plain local bx0 at BX 100
    bx_run = 1'b1;
    step();
    launch(2'd1, 12'd100, 8'd0, 12'd90, n);
    push(n + 11, VBx0 | VDone);
    chk("plain_busy_armed", int'(bus.sw_busy), 1);
    repeat (11) step();
    chk("plain_busy_after", int'(bus.sw_busy), 0);

    // Calpulse then L1A 5 cycles later
    bus.cal_l1a_en = 1'b1;
    launch(2'd2, 12'd10, 8'd5, 12'd5, n);
    push(n + 6, VCal);
    push(n + 11, VL1a | VDone);
    repeat (12) step();

    // Delay 0 behaves as delay 1
    launch(2'd2, 12'd10, 8'd0, 12'd5, n);
    push(n + 6, VCal);
    push(n + 7, VL1a | VDone);
    repeat (8) step();
    bus.cal_l1a_en = 1'b0;

    // Collision: external L1A for 3 cycles from the target BX
    launch(2'd1, 12'd200, 8'd0, 12'd195, n);
    push(n + 6, VL1a);
    push(n + 7, VL1a);
    push(n + 8, VL1a);
    push(n + 9, VBx0 | VDone);
    repeat (4) step();
    bus.ext_l1a = 1'b1;
    repeat (3) step();
    bus.ext_l1a = 1'b0;
    repeat (2) step();
    chk("collision_cnt", int'(bus.collision_cnt), 3);

    // External resync aborts an armed local L1A
    launch(2'd3, 12'd500, 8'd0, 12'd300, n);
    repeat (2) step();
    bus.ext_resync = 1'b1;
    push(n + 4, VRes | VAbt);
    step();
    bus.ext_resync = 1'b0;
    step();
    chk("resync_busy", int'(bus.sw_busy), 0);
    bx_run = 1'b0;
    bus.bxn_counter = 12'd500;
    repeat (5) step();
    bx_run = 1'b1;

    // Clamp 4000 -> 3563, reject while busy and in DONE
    launch(2'd1, 12'd4000, 8'd0, 12'd3555, n);
    push(n + 3, VErr);
    push(n + 9, VBx0 | VDone);
    push(n + 10, VErr);
    step();
    bus.sw_req = 1'b1;
    bus.sw_cmd = 2'd0;
    bus.sw_bx  = 12'd5;
    step();
    bus.sw_req = 1'b0;
    repeat (6) step();
    bus.sw_req = 1'b1;
    step();
    bus.sw_req = 1'b0;
    step();
    chk("reject_busy", int'(bus.sw_busy), 0);

    // Timeout with BX frozen at 0
    bx_run = 1'b0;
    launch(2'd1, 12'd50, 8'd0, 12'd0, n);
    push(n + 7129, VAbt);
    repeat (7127) step();
    chk("timeout_still_busy", int'(bus.sw_busy), 1);
    repeat (2) step();
    step();
    chk("timeout_busy_after", int'(bus.sw_busy), 0);

    // Unmasked pass-through of two external strobes
    bus.ext_bx0      = 1'b1;
    bus.ext_calpulse = 1'b1;
    push(cyc + 1, VBx0 | VCal);
    step();
    bus.ext_bx0      = 1'b0;
    bus.ext_calpulse = 1'b0;
    step();

    // Mask blocks everything
    bus.ext_mask     = 1'b1;
    bus.ext_bx0      = 1'b1;
    bus.ext_resync   = 1'b1;
    bus.ext_l1a      = 1'b1;
    bus.ext_calpulse = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mask_outputs", int'(outvec), 0);
    end
    bus.ext_bx0      = 1'b0;
    bus.ext_resync   = 1'b0;
    bus.ext_l1a      = 1'b0;
    bus.ext_calpulse = 1'b0;
    bus.ext_mask     = 1'b0;
    step();

    // Reset asserted in the calpulse cycle of a sequence headed for CAL_WAIT
    bx_run = 1'b1;
    bus.cal_l1a_en = 1'b1;
    launch(2'd2, 12'd10, 8'd200, 12'd5, n);
    repeat (5) step();
    chk("mid_calpulse", int'(bus.ttc_calpulse), 1);
    chk("mid_busy", int'(bus.sw_busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", int'(outvec), 0);
    chk("mid_reset_busy", int'(bus.sw_busy), 0);
    chk("mid_reset_collision", int'(bus.collision_cnt), 0);
    step();
    step();
    reset = 1'b0;
    bus.cal_l1a_en = 1'b0;
    step();
    chk("post_reset_busy", int'(bus.sw_busy), 0);

    repeat (3) step();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
